// File: rtl/adder_16.sv
// Registered 16-bit two-level carry-lookahead adder/subtractor with signed saturation
// and a packed 4x4-bit lane mode (wrap or saturate). One cycle of latency.
module adder_16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [1:0]  mode,
  output logic [15:0] sum,
  output logic [3:0]  c,
  output logic        ov
);

  localparam int DATA_W = 16;
  localparam int GRP_W  = 4;
  localparam int GRPS   = DATA_W / GRP_W;

  localparam logic [1:0] MODE_SSUB = 2'b01;
  localparam logic [1:0] MODE_LSAT = 2'b11;

  // 4-bit lookahead block: returns {carry_out, sum}
  function automatic logic [GRP_W:0] cla4(input logic [GRP_W-1:0] x,
                                          input logic [GRP_W-1:0] y,
                                          input logic             ci);
    logic [GRP_W-1:0] g;
    logic [GRP_W-1:0] p;
    logic [GRP_W:0]   cc;
    g     = x & y;
    p     = x ^ y;
    cc[0] = ci;
    cc[1] = g[0] | (p[0] & ci);
    cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    cc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (&p & ci);
    return {cc[4], p ^ cc[GRP_W-1:0]};
  endfunction

  function automatic logic grp_g(input logic [GRP_W-1:0] x, input logic [GRP_W-1:0] y);
    logic [GRP_W-1:0] g;
    logic [GRP_W-1:0] p;
    g = x & y;
    p = x ^ y;
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  function automatic logic grp_p(input logic [GRP_W-1:0] x, input logic [GRP_W-1:0] y);
    return &(x ^ y);
  endfunction

  // Signed overflow from sign bits only: equal operand signs, different result sign.
  function automatic logic ovf_pos(input logic sx, input logic sy, input logic sr);
    return ~sx & ~sy & sr;
  endfunction

  function automatic logic ovf_neg(input logic sx, input logic sy, input logic sr);
    return sx & sy & ~sr;
  endfunction

  // Returns {ov, clamped 16-bit result}
  function automatic logic [DATA_W:0] sat16(input logic sx, input logic sy,
                                            input logic [DATA_W-1:0] r);
    if (ovf_pos(sx, sy, r[DATA_W-1]))      return {1'b1, 16'h7FFF};
    else if (ovf_neg(sx, sy, r[DATA_W-1])) return {1'b1, 16'h8000};
    else                                   return {1'b0, r};
  endfunction

  // Returns {ov, lane result}; clamps only when sat is set
  function automatic logic [GRP_W:0] sat4(input logic sx, input logic sy,
                                          input logic [GRP_W-1:0] r, input logic sat);
    logic pos;
    logic neg;
    pos = ovf_pos(sx, sy, r[GRP_W-1]);
    neg = ovf_neg(sx, sy, r[GRP_W-1]);
    if (sat && pos)      return {1'b1, 4'h7};
    else if (sat && neg) return {1'b1, 4'h8};
    else                 return {pos | neg, r};
  endfunction

  logic signed [DATA_W-1:0] a_p0;
  logic signed [DATA_W-1:0] b_p0;
  logic                     sub_p0;
  logic                     lane_p0;
  logic                     lsat_p0;
  logic [GRPS-1:0]          gg_p0;
  logic [GRPS-1:0]          gp_p0;
  logic [GRPS-1:0]          gcin_p0;
  logic [GRPS-1:0]          gcout_p0;
  logic [DATA_W-1:0]        raw_p0;
  logic [DATA_W-1:0]        res_p0;
  logic                     ov_p0;

  logic [DATA_W-1:0]        sum_p1;
  logic [GRPS-1:0]          c_p1;
  logic                     ov_p1;

  // Stage p0: operand conditioning, lookahead network, saturation
  always_comb begin
    sub_p0  = (mode == MODE_SSUB);
    lane_p0 = mode[1];
    lsat_p0 = (mode == MODE_LSAT);
    a_p0    = a;
    b_p0    = sub_p0 ? ~b : b;
  end

  for (genvar k = 0; k < GRPS; k++) begin : g_grp
    assign gg_p0[k] = grp_g(a_p0[GRP_W*k +: GRP_W], b_p0[GRP_W*k +: GRP_W]);
    assign gp_p0[k] = grp_p(a_p0[GRP_W*k +: GRP_W], b_p0[GRP_W*k +: GRP_W]);
    assign {gcout_p0[k], raw_p0[GRP_W*k +: GRP_W]} =
      cla4(a_p0[GRP_W*k +: GRP_W], b_p0[GRP_W*k +: GRP_W], gcin_p0[k]);
  end

  // Second-level lookahead; lanes are isolated by forcing every group carry-in to 0.
  always_comb begin
    gcin_p0 = '0;
    if (!lane_p0) begin
      gcin_p0[0] = sub_p0;
      gcin_p0[1] = gg_p0[0] | (gp_p0[0] & sub_p0);
      gcin_p0[2] = gg_p0[1] | (gp_p0[1] & gg_p0[0]) | (gp_p0[1] & gp_p0[0] & sub_p0);
      gcin_p0[3] = gg_p0[2] | (gp_p0[2] & gg_p0[1]) | (gp_p0[2] & gp_p0[1] & gg_p0[0])
                 | (gp_p0[2] & gp_p0[1] & gp_p0[0] & sub_p0);
    end
  end

  always_comb begin
    logic [GRP_W:0] lane_r;
    res_p0 = raw_p0;
    ov_p0  = 1'b0;
    lane_r = '0;
    if (lane_p0) begin
      for (int k = 0; k < GRPS; k++) begin
        lane_r = sat4(a_p0[GRP_W*k+GRP_W-1], b_p0[GRP_W*k+GRP_W-1],
                      raw_p0[GRP_W*k +: GRP_W], lsat_p0);
        res_p0[GRP_W*k +: GRP_W] = lane_r[GRP_W-1:0];
        ov_p0 = ov_p0 | lane_r[GRP_W];
      end
    end else begin
      {ov_p0, res_p0} = sat16(a_p0[DATA_W-1], b_p0[DATA_W-1], raw_p0);
    end
  end

  // Stage p1: result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_p1 <= '0;
      c_p1   <= '0;
      ov_p1  <= 1'b0;
    end else begin
      sum_p1 <= res_p0;
      c_p1   <= gcout_p0;
      ov_p1  <= ov_p0;
    end
  end

  assign sum = sum_p1;
  assign c   = c_p1;
  assign ov  = ov_p1;

endmodule

// File: tb/tb_adder_16.sv
// Scoreboard bench for adder_16: directed vectors with hand-derived results, then
// back-to-back random operations checked against a widened reference model.
module tb_adder_16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic [1:0]  mode;
  logic [15:0] sum;
  logic [3:0]  c;
  logic        ov;

  adder_16 dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .mode (mode),
    .sum  (sum),
    .c    (c),
    .ov   (ov)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] s;
    logic [3:0]  c;
    logic        ov;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: 20-bit signed arithmetic for modes 00/01, per-lane integers for 10/11.
  task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic [1:0] mm,
                       output logic [15:0] es, output logic [3:0] ec, output logic eov);
    logic signed [19:0] ta;
    logic signed [19:0] tb;
    logic signed [19:0] t;
    logic [15:0]        beff;
    logic [16:0]        msk;
    logic [16:0]        part;
    logic [4:0]         u;
    int                 la;
    int                 lb;
    int                 lt;
    es  = '0;
    ec  = '0;
    eov = 1'b0;
    if (!mm[1]) begin
      ta   = {{4{ma[15]}}, ma};
      tb   = {{4{mb[15]}}, mb};
      t    = mm[0] ? ta - tb : ta + tb;
      beff = mm[0] ? ~mb : mb;
      if (t > 20'sd32767) begin
        es = 16'h7FFF; eov = 1'b1;
      end else if (t < -20'sd32768) begin
        es = 16'h8000; eov = 1'b1;
      end else begin
        es = t[15:0];
      end
      for (int k = 0; k < 4; k++) begin
        msk   = (17'd1 << (4*k + 4)) - 17'd1;
        part  = ({1'b0, ma} & msk) + ({1'b0, beff} & msk) + {16'd0, mm[0]};
        ec[k] = part[4*k + 4];
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        u     = {1'b0, ma[4*k +: 4]} + {1'b0, mb[4*k +: 4]};
        ec[k] = u[4];
        la    = $signed(ma[4*k +: 4]);
        lb    = $signed(mb[4*k +: 4]);
        lt    = la + lb;
        es[4*k +: 4] = u[3:0];
        if (lt > 7) begin
          eov = 1'b1;
          if (mm[0]) es[4*k +: 4] = 4'h7;
        end else if (lt < -8) begin
          eov = 1'b1;
          if (mm[0]) es[4*k +: 4] = 4'h8;
        end
      end
    end
  endtask

  task automatic cycle(input logic r, input logic [15:0] da, input logic [15:0] db,
                       input logic [1:0] dm, input exp_t e);
    exp_t got_e;
    rst  = r;
    a    = da;
    b    = db;
    mode = dm;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      got_e = sb_q.pop_front();
      chk({got_e.tag, ".sum"}, {16'd0, sum}, {16'd0, got_e.s});
      chk({got_e.tag, ".c"},   {28'd0, c},   {28'd0, got_e.c});
      chk({got_e.tag, ".ov"},  {31'd0, ov},  {31'd0, got_e.ov});
    end
  endtask

  task automatic op_exp(input string tag, input logic r, input logic [15:0] da,
                        input logic [15:0] db, input logic [1:0] dm,
                        input logic [15:0] es, input logic [3:0] ec, input logic eov);
    exp_t e;
    e.tag = tag;
    e.s   = es;
    e.c   = ec;
    e.ov  = eov;
    cycle(r, da, db, dm, e);
  endtask

  task automatic op_model(input string tag, input logic r, input logic [15:0] da,
                          input logic [15:0] db, input logic [1:0] dm);
    exp_t e;
    e.tag = tag;
    if (r) begin
      e.s = '0; e.c = '0; e.ov = 1'b0;
    end else begin
      model(da, db, dm, e.s, e.c, e.ov);
    end
    cycle(r, da, db, dm, e);
  endtask

  function automatic logic [15:0] pick();
    logic [15:0] edges [6];
    edges[0] = 16'h7FFF; edges[1] = 16'h8000; edges[2] = 16'hFFFF;
    edges[3] = 16'h0000; edges[4] = 16'h7777; edges[5] = 16'h8888;
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 5)];
    return 16'($urandom());
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; a = 16'h1234; b = 16'h1111; mode = 2'b00;

    op_exp("rst0", 1'b1, 16'h1234, 16'h1111, 2'b00, 16'h0000, 4'h0, 1'b0);
    op_exp("rst1", 1'b1, 16'h1234, 16'h1111, 2'b00, 16'h0000, 4'h0, 1'b0);
    op_exp("rel",  1'b0, 16'h1234, 16'h1111, 2'b00, 16'h2345, 4'h0, 1'b0);

    op_exp("add_max", 1'b0, 16'h7FFF, 16'h0001, 2'b00, 16'h7FFF, 4'b0111, 1'b1);
    op_exp("add_mix", 1'b0, 16'd100,  16'hFFE2, 2'b00, 16'd70,   4'b1110, 1'b0);
    op_exp("sub_min", 1'b0, 16'h8000, 16'h0001, 2'b01, 16'h8000, 4'b1000, 1'b1);
    op_exp("sub_neg", 1'b0, 16'd5,    16'd7,    2'b01, 16'hFFFE, 4'b0000, 1'b0);
    op_exp("sub_b8k", 1'b0, 16'h0000, 16'h8000, 2'b01, 16'h7FFF, 4'b0111, 1'b1);

    op_exp("wrap_pos", 1'b0, 16'h7777, 16'h1111, 2'b10, 16'h8888, 4'h0, 1'b1);
    op_exp("wrap_neg", 1'b0, 16'h8888, 16'h8888, 2'b10, 16'h0000, 4'hF, 1'b1);
    op_exp("lsat_pos", 1'b0, 16'h7777, 16'h1111, 2'b11, 16'h7777, 4'h0, 1'b1);
    op_exp("lsat_neg", 1'b0, 16'h8888, 16'h8888, 2'b11, 16'h8888, 4'hF, 1'b1);
    op_exp("lsat_ok",  1'b0, 16'h1234, 16'h2121, 2'b11, 16'h3355, 4'h0, 1'b0);

    op_model("pre_rst", 1'b0, 16'h7FFF, 16'h7FFF, 2'b00);
    op_exp("mid_rst",   1'b1, 16'h7FFF, 16'h7FFF, 2'b00, 16'h0000, 4'h0, 1'b0);
    op_model("post_rst", 1'b0, 16'h8888, 16'h7777, 2'b11);

    for (int i = 0; i < 1200; i++) begin
      op_model("rand", 1'b0, pick(), pick(), 2'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
